// File: rtl/paicore_pkg.sv
// Shared types and constants for the PAICORE receive path.
// Frame/word widths, lane FSM encoding, default half-frame timeout.
package paicore_pkg;

  localparam int FRAME_W         = 64;
  localparam int WORD_W          = 32;
  localparam int DEFAULT_TIMEOUT = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } lane_state_e;

endpackage

// File: rtl/paicore_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Head entry is visible on dout whenever the FIFO is not empty.
module paicore_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/paicore_recv_lane.sv
// One PAICORE receive lane: 4-phase req/ack sink, word pairing,
// frame FIFO and AXI-Stream master output.
module paicore_recv_lane
  import paicore_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic               m_axis_aclk,
  input  logic               m_axis_aresetn,
  input  logic               en,
  input  logic               clr_err,
  input  logic               request,
  input  logic [WORD_W-1:0]  din,
  output logic               acknowledge,
  input  logic               m_axis_tready,
  output logic [FRAME_W-1:0] m_axis_tdata,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  output logic [31:0]        frame_cnt,
  output logic               err_half_frame
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  lane_state_e            state;
  logic                   half;
  logic [WORD_W-1:0]      hold;
  logic [15:0]            tmo_cnt;

  logic                   capture;
  logic                   push;
  logic                   tmo_run;
  logic                   tmo_hit;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_unused;

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign capture = (state == IDLE) && req_s && en && !fifo_full;
  assign push    = capture && half;
  assign tmo_run = half && (state == IDLE) && !req_s;
  assign tmo_hit = tmo_run && (tmo_cnt == TMO_LAST);

  assign m_axis_tlast  = 1'b0;
  assign m_axis_tvalid = !fifo_empty;
  assign fifo_unused   = &{1'b0, fifo_count};

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) sync_q <= '0;
    else                 sync_q <= {sync_q[SYNC_STAGES-2:0], request};
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state          <= IDLE;
      acknowledge    <= 1'b0;
      half           <= 1'b0;
      hold           <= '0;
      tmo_cnt        <= '0;
      frame_cnt      <= '0;
      err_half_frame <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (capture) begin
          state       <= ACK;
          acknowledge <= 1'b1;
        end
        ACK: if (!req_s) begin
          state       <= IDLE;
          acknowledge <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Capture has priority over an expiring half-frame timer.
      if (capture) begin
        tmo_cnt <= '0;
        if (half) begin
          half      <= 1'b0;
          frame_cnt <= frame_cnt + 32'd1;
        end else begin
          hold <= din;
          half <= 1'b1;
        end
      end else if (tmo_run) begin
        if (tmo_hit) begin
          half    <= 1'b0;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 16'd1;
        end
      end

      if (tmo_hit)      err_half_frame <= 1'b1;
      else if (clr_err) err_half_frame <= 1'b0;
    end
  end

  paicore_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_W)
  ) u_fifo (
    .clk   (m_axis_aclk),
    .rst_n (m_axis_aresetn),
    .push  (push),
    .din   ({hold, din}),
    .pop   (m_axis_tvalid && m_axis_tready),
    .dout  (m_axis_tdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_paicore_recv_lane.sv
// Directed self-checking bench for paicore_recv_lane.
// Acts as the chip side of the 4-phase handshake and as the AXIS sink.
module tb_paicore_recv_lane;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        clr_err = 1'b0;
  logic        request = 1'b0;
  logic [31:0] din = '0;
  logic        acknowledge;
  logic        tready = 1'b0;
  logic [63:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic [31:0] frame_cnt;
  logic        err_half_frame;

  int checks = 0;
  int errors = 0;
  logic [63:0] beats [$];

  paicore_recv_lane #(
    .SYNC_STAGES (2),
    .FIFO_DEPTH  (4),
    .TIMEOUT     (1024)
  ) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rst_n),
    .en             (en),
    .clr_err        (clr_err),
    .request        (request),
    .din            (din),
    .acknowledge    (acknowledge),
    .m_axis_tready  (tready),
    .m_axis_tdata   (tdata),
    .m_axis_tlast   (tlast),
    .m_axis_tvalid  (tvalid),
    .frame_cnt      (frame_cnt),
    .err_half_frame (err_half_frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tvalid && tready) beats.push_back(tdata);
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (acknowledge !== lvl && n < 200);
    if (acknowledge !== lvl) check("ack_wait", {63'd0, acknowledge}, {63'd0, lvl});
  endtask

  task automatic send_word(input logic [31:0] w, output int rise,
                           output int fall);
    @(negedge clk);
    din     = w;
    request = 1'b1;
    wait_ack(1'b1, rise);
    @(negedge clk);
    request = 1'b0;
    wait_ack(1'b0, fall);
  endtask

  initial begin
    int r, f, n;
    logic [31:0] w [10];

    cycles(3);
    check("rst_ack", {63'd0, acknowledge}, 64'd0);
    check("rst_tvalid", {63'd0, tvalid}, 64'd0);
    check("rst_tdata", tdata, 64'd0);
    check("rst_cnt", {32'd0, frame_cnt}, 64'd0);
    check("rst_err", {63'd0, err_half_frame}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);

    // Basic pairing with handshake latency
    tready = 1'b1;
    send_word(32'hA5A5_0001, r, f);
    check("ack_rise_lat", r, 64'd3);
    check("ack_fall_lat", f, 64'd3);
    check("tlast", {63'd0, tlast}, 64'd0);
    send_word(32'h5A5A_0002, r, f);
    cycles(3);
    check("basic_beats", beats.size(), 64'd1);
    if (beats.size() > 0) check("basic_data", beats[0], 64'hA5A5_0001_5A5A_0002);
    check("basic_cnt", {32'd0, frame_cnt}, 64'd1);

    // Backpressure: FIFO fills, 9th word stalls
    @(negedge clk);
    tready = 1'b0;
    beats.delete();
    for (int i = 0; i < 10; i++) w[i] = 32'h1000_0000 + i;
    for (int i = 0; i < 8; i++) send_word(w[i], r, f);
    check("bp_tvalid", {63'd0, tvalid}, 64'd1);
    check("bp_head", tdata, {w[0], w[1]});
    @(negedge clk);
    din = w[8];
    request = 1'b1;
    cycles(20);
    check("bp_stall_ack", {63'd0, acknowledge}, 64'd0);
    check("bp_hold_head", tdata, {w[0], w[1]});
    @(negedge clk);
    tready = 1'b1;
    wait_ack(1'b1, n);
    @(negedge clk);
    request = 1'b0;
    wait_ack(1'b0, n);
    send_word(w[9], r, f);
    cycles(10);
    check("bp_beats", beats.size(), 64'd5);
    for (int k = 0; k < 5; k++)
      if (k < beats.size()) check("bp_order", beats[k], {w[2*k], w[2*k+1]});
    check("bp_cnt", {32'd0, frame_cnt}, 64'd6);

    // Half-frame timeout
    beats.delete();
    send_word(32'h1234_5678, r, f);
    cycles(1000);
    check("tmo_early", {63'd0, err_half_frame}, 64'd0);
    cycles(25);
    check("tmo_err", {63'd0, err_half_frame}, 64'd1);
    check("tmo_nobeat", beats.size(), 64'd0);
    check("tmo_tvalid", {63'd0, tvalid}, 64'd0);
    send_word(32'h0000_0001, r, f);
    send_word(32'h0000_0002, r, f);
    cycles(3);
    check("tmo_beats", beats.size(), 64'd1);
    if (beats.size() > 0) check("tmo_data", beats[0], 64'h0000_0001_0000_0002);
    check("tmo_err_held", {63'd0, err_half_frame}, 64'd1);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("tmo_clr", {63'd0, err_half_frame}, 64'd0);
    check("tmo_cnt", {32'd0, frame_cnt}, 64'd7);

    // Enable gating
    beats.delete();
    @(negedge clk);
    en = 1'b0;
    din = 32'h0000_00E0;
    request = 1'b1;
    cycles(50);
    check("en_block", {63'd0, acknowledge}, 64'd0);
    @(negedge clk);
    en = 1'b1;
    wait_ack(1'b1, n);
    check("en_ack", {63'd0, acknowledge}, 64'd1);
    @(negedge clk);
    request = 1'b0;
    wait_ack(1'b0, n);
    @(negedge clk);
    din = 32'h0000_00E1;
    request = 1'b1;
    wait_ack(1'b1, n);
    @(negedge clk);
    en = 1'b0;
    request = 1'b0;
    wait_ack(1'b0, n);
    check("en_drop_done", {63'd0, acknowledge}, 64'd0);
    @(negedge clk);
    en = 1'b1;
    cycles(3);
    check("en_beats", beats.size(), 64'd1);
    if (beats.size() > 0) check("en_data", beats[0], 64'h0000_00E0_0000_00E1);

    // Asynchronous reset mid-handshake
    @(negedge clk);
    tready = 1'b0;
    send_word(32'h0000_00B0, r, f);
    send_word(32'h0000_00B1, r, f);
    @(negedge clk);
    din = 32'h0000_00B2;
    request = 1'b1;
    wait_ack(1'b1, n);
    check("pre_rst_tvalid", {63'd0, tvalid}, 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ack", {63'd0, acknowledge}, 64'd0);
    check("arst_tvalid", {63'd0, tvalid}, 64'd0);
    check("arst_cnt", {32'd0, frame_cnt}, 64'd0);
    request = 1'b0;
    cycles(3);
    @(negedge clk);
    rst_n = 1'b1;
    tready = 1'b1;
    beats.delete();
    send_word(32'h0000_00C0, r, f);
    send_word(32'h0000_00C1, r, f);
    cycles(3);
    check("post_rst_beats", beats.size(), 64'd1);
    if (beats.size() > 0) check("post_rst_data", beats[0], 64'h0000_00C0_0000_00C1);
    check("post_rst_cnt", {32'd0, frame_cnt}, 64'd1);

    // frame_cnt wrap
    @(negedge clk);
    force dut.frame_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.frame_cnt;
    #1;
    check("wrap_pre", {32'd0, frame_cnt}, 64'h0000_0000_FFFF_FFFF);
    send_word(32'h0000_00D0, r, f);
    send_word(32'h0000_00D1, r, f);
    cycles(2);
    check("wrap_cnt", {32'd0, frame_cnt}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
